clause_eval: RTL and testbench

Inference-side counterpart of the TA feedback stage in the Tsetlin-machine datapath. The block reads TA states from the clause state memory and derives each TA's include/exclude action. It evaluates every clause's conjunction against a latched literal vector and produces the `conjunction_result` vector that the feedback stage consumes. Clauses are processed serially, CHUNK literals per cycle, through a one-cycle-latency memory read port.

---
 rtl/clause_eval.sv | 188 ++++++++++++++++++
 tb/tb_clause_eval.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clause_eval.sv
// Tsetlin-machine clause evaluator: streams TA states chunk by chunk from the clause
// state memory and builds the per-clause conjunction result vector for one latched sample.
module clause_eval #(
  parameter int CLAUSE_NUM  = 128,
  parameter int LITERAL_NUM = 272,
  parameter int STATE_WIDTH = 8,
  parameter int CHUNK       = 16,
  parameter int ADDR_WIDTH  = $clog2(CLAUSE_NUM * (LITERAL_NUM / CHUNK))
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             train,
  input  logic [LITERAL_NUM-1:0]           literals,
  output logic                             mem_rd_en,
  output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
  input  logic [CHUNK*STATE_WIDTH-1:0]     mem_rd_data,
  output logic                             busy,
  output logic                             clause_valid,
  output logic [$clog2(CLAUSE_NUM)-1:0]    clause_idx,
  output logic                             clause_out,
  output logic [CLAUSE_NUM-1:0]            conjunction_result,
  output logic                             done
);

  localparam int CHUNKS  = LITERAL_NUM / CHUNK;
  localparam int IDX_W   = $clog2(CLAUSE_NUM);
  localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int LIT_W   = $clog2(LITERAL_NUM);
  localparam logic [STATE_WIDTH-1:0] INCLUDE_TH = {1'b1, {(STATE_WIDTH-1){1'b0}}};

  if (LITERAL_NUM % CHUNK != 0) begin : g_bad_chunk
    $error("clause_eval: LITERAL_NUM must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                   state_q;
  logic [LITERAL_NUM-1:0]   literals_q;
  logic                     train_q;
  logic [IDX_W-1:0]         clause_q;
  logic [CHUNK_W-1:0]       chunk_q;
  logic                     mem_rd_en_q;
  logic [ADDR_WIDTH-1:0]    mem_rd_addr_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     tag_en_q;
  logic [IDX_W-1:0]         tag_clause_q;
  logic [CHUNK_W-1:0]       tag_chunk_q;
  logic                     miss_q;
  logic                     any_q;
  logic                     clause_valid_q;
  logic [IDX_W-1:0]         clause_idx_q;
  logic                     clause_out_q;
  logic [CLAUSE_NUM-1:0]    conj_q;

  logic [LIT_W-1:0]         lit_base_d;
  logic [CHUNK-1:0]         lit_slice_d;
  logic [CHUNK-1:0]         include_d;
  logic                     chunk_miss_d;
  logic                     chunk_any_d;
  logic                     first_chunk_d;
  logic                     last_chunk_d;
  logic                     miss_d;
  logic                     any_d;
  logic                     clause_val_d;

  // Evaluate the returning chunk against the literal slice selected by its tag
  always_comb begin
    lit_base_d  = LIT_W'(tag_chunk_q) * LIT_W'(CHUNK);
    lit_slice_d = literals_q[lit_base_d +: CHUNK];
    include_d   = '0;
    for (int j = 0; j < CHUNK; j++) begin
      include_d[j] = (mem_rd_data[j*STATE_WIDTH +: STATE_WIDTH] >= INCLUDE_TH);
    end
    chunk_any_d   = |include_d;
    chunk_miss_d  = |(include_d & ~lit_slice_d);
    first_chunk_d = (tag_chunk_q == CHUNK_W'(0));
    last_chunk_d  = (tag_chunk_q == CHUNK_W'(CHUNKS - 1));
    if (first_chunk_d) begin
      miss_d = chunk_miss_d;
      any_d  = chunk_any_d;
    end else begin
      miss_d = miss_q | chunk_miss_d;
      any_d  = any_q | chunk_any_d;
    end
    if (any_d) begin
      clause_val_d = ~miss_d;
    end else begin
      clause_val_d = train_q;
    end
  end

  // Pass sequencer, read-tag pipeline and registered clause results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      literals_q     <= '0;
      train_q        <= 1'b0;
      clause_q       <= '0;
      chunk_q        <= '0;
      mem_rd_en_q    <= 1'b0;
      mem_rd_addr_q  <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      tag_en_q       <= 1'b0;
      tag_clause_q   <= '0;
      tag_chunk_q    <= '0;
      miss_q         <= 1'b0;
      any_q          <= 1'b0;
      clause_valid_q <= 1'b0;
      clause_idx_q   <= '0;
      clause_out_q   <= 1'b0;
      conj_q         <= '0;
    end else begin
      tag_en_q       <= mem_rd_en_q;
      tag_clause_q   <= clause_q;
      tag_chunk_q    <= chunk_q;
      clause_valid_q <= 1'b0;
      done_q         <= 1'b0;

      if (tag_en_q) begin
        miss_q <= miss_d;
        any_q  <= any_d;
        if (last_chunk_d) begin
          conj_q[tag_clause_q] <= clause_val_d;
          clause_out_q         <= clause_val_d;
          clause_idx_q         <= tag_clause_q;
          clause_valid_q       <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            literals_q    <= literals;
            train_q       <= train;
            conj_q        <= '0;
            clause_q      <= '0;
            chunk_q       <= '0;
            mem_rd_addr_q <= '0;
            mem_rd_en_q   <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= S_RUN;
          end
        end
        S_RUN: begin
          // Terminal count stops issuing; counters never wrap past the last clause
          if ((clause_q == IDX_W'(CLAUSE_NUM - 1)) && (chunk_q == CHUNK_W'(CHUNKS - 1))) begin
            mem_rd_en_q <= 1'b0;
            state_q     <= S_DRAIN;
          end else begin
            mem_rd_addr_q <= mem_rd_addr_q + ADDR_WIDTH'(1);
            if (chunk_q == CHUNK_W'(CHUNKS - 1)) begin
              chunk_q  <= '0;
              clause_q <= clause_q + IDX_W'(1);
            end else begin
              chunk_q <= chunk_q + CHUNK_W'(1);
            end
          end
        end
        S_DRAIN: begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          mem_rd_en_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd_en          = mem_rd_en_q;
  assign mem_rd_addr        = mem_rd_addr_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign clause_valid       = clause_valid_q;
  assign clause_idx         = clause_idx_q;
  assign clause_out         = clause_out_q;
  assign conjunction_result = conj_q;

endmodule

// File: tb/tb_clause_eval.sv
// Directed bench for clause_eval with 4 clauses x 32 literals in 16-literal chunks,
// backed by a one-cycle-latency behavioural state memory.
module tb_clause_eval;

  localparam int CN = 4;
  localparam int LN = 32;
  localparam int SW = 8;
  localparam int CK = 16;
  localparam int NW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              train = 1'b0;
  logic [LN-1:0]     literals = '0;
  logic              mem_rd_en;
  logic [2:0]        mem_rd_addr;
  logic [CK*SW-1:0]  mem_rd_data = '0;
  logic              busy;
  logic              clause_valid;
  logic [1:0]        clause_idx;
  logic              clause_out;
  logic [CN-1:0]     conjunction_result;
  logic              done;

  logic [CK*SW-1:0]  mem [0:NW-1];
  int                checks = 0;
  int                failures = 0;

  logic              rec_en    [0:15];
  logic [2:0]        rec_addr  [0:15];
  logic              rec_busy  [0:15];
  logic              rec_valid [0:15];
  logic [1:0]        rec_idx   [0:15];
  logic              rec_out   [0:15];
  logic              rec_done  [0:15];
  logic [CN-1:0]     rec_conj  [0:15];

  clause_eval #(
    .CLAUSE_NUM(CN), .LITERAL_NUM(LN), .STATE_WIDTH(SW), .CHUNK(CK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .train(train), .literals(literals),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .busy(busy), .clause_valid(clause_valid), .clause_idx(clause_idx),
    .clause_out(clause_out), .conjunction_result(conjunction_result), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic fill_states(input logic [7:0] v);
    for (int w = 0; w < NW; w++)
      for (int j = 0; j < CK; j++) mem[w][j*SW +: SW] = v;
  endtask

  task automatic set_state(input int cl, input int lit, input logic [7:0] v);
    mem[cl*2 + lit/16][(lit%16)*SW +: SW] = v;
  endtask

  // Start a pass in cycle 0 and record outputs in cycles 1..ncyc
  task automatic capture_pass(input logic tr, input logic [31:0] lits, input int ncyc,
                              input int restart_cyc, input logic [31:0] lits_after);
    @(negedge clk);
    train = tr; literals = lits; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      start = (k == restart_cyc);
      literals = lits_after;
      train = ~tr;
      rec_en[k] = mem_rd_en;       rec_addr[k] = mem_rd_addr;
      rec_busy[k] = busy;          rec_valid[k] = clause_valid;
      rec_idx[k] = clause_idx;     rec_out[k] = clause_out;
      rec_done[k] = done;          rec_conj[k] = conjunction_result;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    logic [13:0] outs;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {mem_rd_en, mem_rd_addr, busy, clause_valid, clause_idx, clause_out, conjunction_result, done};
    checks++;
    if (outs !== 14'd0) begin failures++; $display("FAIL reset_hold got=%h exp=0", outs); end
    rst_n = 1'b1;
    @(negedge clk);
    outs = {mem_rd_en, mem_rd_addr, busy, clause_valid, clause_idx, clause_out, conjunction_result, done};
    checks++;
    if (outs !== 14'd0) begin failures++; $display("FAIL reset_idle got=%h exp=0", outs); end
  endtask

  task automatic test_empty_infer;
    logic e_en, e_busy, e_done, e_valid;
    fill_states(8'h00);
    capture_pass(1'b0, 32'hA5A5_F00F, 14, 0, 32'h5A5A_0FF0);
    for (int k = 1; k <= 14; k++) begin
      e_en = (k <= 8); e_busy = (k <= 10); e_done = (k == 10);
      e_valid = (k >= 4) && (k <= 10) && (k % 2 == 0);
      checks++;
      if (rec_en[k] !== e_en) begin failures++; $display("FAIL infer_rd_en cyc=%0d got=%b exp=%b", k, rec_en[k], e_en); end
      checks++;
      if (rec_busy[k] !== e_busy) begin failures++; $display("FAIL infer_busy cyc=%0d got=%b exp=%b", k, rec_busy[k], e_busy); end
      checks++;
      if (rec_done[k] !== e_done) begin failures++; $display("FAIL infer_done cyc=%0d got=%b exp=%b", k, rec_done[k], e_done); end
      checks++;
      if (rec_valid[k] !== e_valid) begin failures++; $display("FAIL infer_valid cyc=%0d got=%b exp=%b", k, rec_valid[k], e_valid); end
      if (e_en) begin
        checks++;
        if (rec_addr[k] !== 3'(k-1)) begin failures++; $display("FAIL infer_addr cyc=%0d got=%0d exp=%0d", k, rec_addr[k], k-1); end
      end
    end
    checks++;
    if (rec_conj[14] !== 4'b0000) begin failures++; $display("FAIL infer_result got=%b exp=0000", rec_conj[14]); end
  endtask

  task automatic test_empty_train;
    int k;
    fill_states(8'h00);
    capture_pass(1'b1, 32'h0000_0000, 14, 0, 32'hFFFF_FFFF);
    for (int c = 0; c < CN; c++) begin
      k = (c + 1) * 2 + 2;
      checks++;
      if ({rec_valid[k], rec_idx[k], rec_out[k]} !== {1'b1, 2'(c), 1'b1}) begin
        failures++;
        $display("FAIL train_clause cyc=%0d got=%b%b%b exp=1_%0d_1", k, rec_valid[k], rec_idx[k], rec_out[k], c);
      end
    end
    checks++;
    if (rec_conj[10] !== 4'b1111) begin failures++; $display("FAIL train_result_done got=%b exp=1111", rec_conj[10]); end
    checks++;
    if (rec_conj[14] !== 4'b1111) begin failures++; $display("FAIL train_result_hold got=%b exp=1111", rec_conj[14]); end
  endtask

  task automatic test_include_hit;
    fill_states(8'h7F);
    set_state(2, 3, 8'h80);
    set_state(2, 20, 8'hFF);
    capture_pass(1'b0, 32'h0010_0008, 14, 0, 32'h0000_0000);
    checks++;
    if ({rec_valid[8], rec_idx[8], rec_out[8]} !== 4'b1101) begin
      failures++; $display("FAIL hit_clause2 got=%b%b%b exp=1101", rec_valid[8], rec_idx[8], rec_out[8]);
    end
    checks++;
    if (rec_conj[14] !== 4'b0100) begin failures++; $display("FAIL hit_result got=%b exp=0100", rec_conj[14]); end
  endtask

  task automatic test_include_miss;
    capture_pass(1'b0, 32'h0000_0008, 14, 0, 32'h0010_0008);
    checks++;
    if (rec_out[8] !== 1'b0) begin failures++; $display("FAIL miss_clause2 got=%b exp=0", rec_out[8]); end
    checks++;
    if (rec_conj[14] !== 4'b0000) begin failures++; $display("FAIL miss_result got=%b exp=0000", rec_conj[14]); end
  endtask

  task automatic test_last_chunk;
    fill_states(8'h7F);
    set_state(0, 31, 8'h80);
    capture_pass(1'b0, 32'h8000_0000, 14, 0, 32'h0000_0000);
    checks++;
    if (rec_conj[14] !== 4'b0001) begin failures++; $display("FAIL last_hit_result got=%b exp=0001", rec_conj[14]); end
    capture_pass(1'b0, 32'h7FFF_FFFF, 14, 0, 32'hFFFF_FFFF);
    checks++;
    if (rec_conj[14] !== 4'b0000) begin failures++; $display("FAIL last_miss_result got=%b exp=0000", rec_conj[14]); end
  endtask

  task automatic test_start_ignored;
    int ndone;
    fill_states(8'h7F);
    set_state(2, 3, 8'h80);
    set_state(2, 20, 8'hFF);
    capture_pass(1'b0, 32'h0010_0008, 14, 5, 32'h0000_0000);
    ndone = 0;
    for (int k = 1; k <= 14; k++) ndone += int'(rec_done[k]);
    checks++;
    if (ndone !== 1) begin failures++; $display("FAIL restart_done_count got=%0d exp=1", ndone); end
    checks++;
    if (rec_done[10] !== 1'b1) begin failures++; $display("FAIL restart_done_cycle got=%b exp=1", rec_done[10]); end
    checks++;
    if (rec_conj[14] !== 4'b0100) begin failures++; $display("FAIL restart_result got=%b exp=0100", rec_conj[14]); end
  endtask

  task automatic test_back_to_back;
    fill_states(8'h00);
    capture_pass(1'b1, 32'h0000_0000, 10, 0, 32'h0000_0000);
    checks++;
    if ({rec_done[10], rec_conj[10]} !== 5'b1_1111) begin
      failures++; $display("FAIL b2b_first got=%b%b exp=11111", rec_done[10], rec_conj[10]);
    end
    capture_pass(1'b0, 32'h0000_0000, 14, 0, 32'h0000_0000);
    checks++;
    if ({rec_en[1], rec_busy[1], rec_conj[1]} !== 6'b11_0000) begin
      failures++; $display("FAIL b2b_second_start got=%b%b%b exp=110000", rec_en[1], rec_busy[1], rec_conj[1]);
    end
    checks++;
    if ({rec_done[10], rec_conj[14]} !== 5'b1_0000) begin
      failures++; $display("FAIL b2b_second_result got=%b%b exp=10000", rec_done[10], rec_conj[14]);
    end
  endtask

  task automatic test_reset_mid_pass;
    logic [13:0] outs;
    int ndone;
    fill_states(8'h00);
    @(negedge clk);
    train = 1'b1; literals = 32'h0000_0000; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if ({busy, conjunction_result} !== 5'b1_0011) begin
      failures++; $display("FAIL midrst_before got=%b%b exp=10011", busy, conjunction_result);
    end
    rst_n = 1'b0;
    #1;
    outs = {mem_rd_en, mem_rd_addr, busy, clause_valid, clause_idx, clause_out, conjunction_result, done};
    checks++;
    if (outs !== 14'd0) begin failures++; $display("FAIL midrst_outputs got=%h exp=0", outs); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      ndone += int'(done) + int'(busy);
    end
    checks++;
    if (ndone !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", ndone); end
    fill_states(8'h7F);
    set_state(2, 3, 8'h80);
    set_state(2, 20, 8'hFF);
    capture_pass(1'b0, 32'h0010_0008, 14, 0, 32'h0000_0000);
    checks++;
    if ({rec_done[10], rec_conj[14]} !== 5'b1_0100) begin
      failures++; $display("FAIL midrst_rerun got=%b%b exp=10100", rec_done[10], rec_conj[14]);
    end
  endtask

  initial begin
    test_reset();
    test_empty_infer();
    test_empty_train();
    test_include_hit();
    test_include_miss();
    test_last_chunk();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
